alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu4_core.sv | 32 +++
 rtl/alu_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer slice.
//   op_e      : command opcode encoding carried on cmd_op
//   state_e   : sequencer FSM states (also driven onto dbg_state)
//   OPW       : operand width
//   RSPW      : response data width
//   MUL_STEPS : number of shift-add iterations for a multiply
package alu_seq_pkg;

  localparam int OPW       = 4;
  localparam int RSPW      = 8;
  localparam int MUL_STEPS = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU datapath shared by every sequencer operation.
//   a, b    : operands
//   sub     : 1 -> y = a + ~b + 1 (cout is the inverted borrow)
//   sel_xor : 1 -> y = a ^ b, cout = 0 (takes priority over sub)
//   y, cout : 4-bit result and carry out
module alu4_core
  import alu_seq_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic           sub,
  input  logic           sel_xor,
  output logic [OPW-1:0] y,
  output logic           cout
);

  logic [OPW-1:0] b_eff;
  logic [OPW:0]   sum;

  always_comb begin
    b_eff = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{OPW{1'b0}}, sub};
    if (sel_xor) begin
      y    = a ^ b;
      cout = 1'b0;
    end else begin
      y    = sum[OPW-1:0];
      cout = sum[OPW];
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command/response sequencer around a single alu4_core instance.
// ADD/SUB/XOR take one EXEC cycle; MUL runs a 4-step shift-add on the core.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. cmd_ready is high only in IDLE. rsp_valid is high only in RESP and
// once raised holds rsp_data/rsp_err stable until the edge with rsp_ready=1.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    : command handshake
//   cmd_op, cmd_a, cmd_b   : opcode (op_e) and unsigned 4-bit operands
//   rsp_valid/rsp_ready    : response handshake
//   rsp_data, rsp_err      : 8-bit result, unsupported-op flag
//   busy                   : high whenever the FSM is not in IDLE
//   dbg_state              : current FSM state (state_e encoding)
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ENABLE_MUL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [OPW-1:0]  cmd_a,
  input  logic [OPW-1:0]  cmd_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [RSPW-1:0] rsp_data,
  output logic            rsp_err,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] LAST_STEP = 2'(MUL_STEPS - 1);
  localparam logic       MUL_ON    = (ENABLE_MUL != 0);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [OPW-1:0]  a_q, a_d;
  logic [OPW-1:0]  b_q, b_d;
  logic [OPW-1:0]  p_hi_q, p_hi_d;
  logic [OPW-1:0]  p_lo_q, p_lo_d;
  logic [1:0]      step_q, step_d;
  logic [RSPW-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [OPW-1:0]  core_a, core_b, core_y;
  logic            core_sub, core_xor, core_cout;

  // Partial-product high half and carry after the conditional add of a step
  logic [OPW-1:0]  mul_hi;
  logic            mul_c;

  alu4_core u_core (
    .a       (core_a),
    .b       (core_b),
    .sub     (core_sub),
    .sel_xor (core_xor),
    .y       (core_y),
    .cout    (core_cout)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    p_hi_d      = p_hi_q;
    p_lo_d      = p_lo_q;
    step_d      = step_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    core_a      = a_q;
    core_b      = b_q;
    core_sub    = 1'b0;
    core_xor    = 1'b0;
    mul_hi      = p_hi_q;
    mul_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          a_d    = cmd_a;
          b_d    = cmd_b;
          op_d   = op_e'(cmd_op);
          p_hi_d = '0;
          p_lo_d = cmd_b;
          step_d = '0;
          if (op_e'(cmd_op) == OP_MUL && MUL_ON) state_d = ST_MUL;
          else                                   state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        core_sub  = (op_q == OP_SUB);
        core_xor  = (op_q == OP_XOR);
        rsp_err_d = 1'b0;
        state_d   = ST_RESP;
        case (op_q)
          OP_ADD:  rsp_data_d = {3'b000, core_cout, core_y};
          // Core computes a + ~b + 1, so no carry out means a borrow.
          OP_SUB:  rsp_data_d = {3'b000, ~core_cout, core_y};
          OP_XOR:  rsp_data_d = {4'b0000, core_y};
          // Only reached for MUL when the multiplier is disabled.
          default: begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end
        endcase
      end

      ST_MUL: begin
        core_b = p_hi_q;
        if (p_lo_q[0]) begin
          mul_c  = core_cout;
          mul_hi = core_y;
        end
        // Shift {C, P_hi, P_lo} right by one.
        p_hi_d = {mul_c, mul_hi[OPW-1:1]};
        p_lo_d = {mul_hi[0], p_lo_q[OPW-1:1]};
        step_d = step_q + 2'd1;
        if (step_q == LAST_STEP) begin
          state_d    = ST_RESP;
          rsp_data_d = {p_hi_d, p_lo_d};
          rsp_err_d  = 1'b0;
        end
      end

      ST_RESP: begin
        // First RESP cycle raises rsp_valid; a consumer can only complete the
        // handshake once rsp_valid is visible, so rsp_ready before that is
        // ignored.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      p_hi_q      <= '0;
      p_lo_q      <= '0;
      step_q      <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p_hi_q      <= p_hi_d;
      p_lo_q      <= p_lo_d;
      step_q      <= step_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer: one default instance (multiplier
// enabled) and one with ENABLE_MUL=0 for the error path.
module tb_alu_sequencer;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_a = 4'h0;
  logic [3:0] cmd_b = 4'h0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic [1:0] dbg_state;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- multiplier-disabled DUT ----------------
  logic       nm_cmd_valid = 1'b0;
  logic       nm_cmd_ready;
  logic [1:0] nm_cmd_op = 2'b00;
  logic [3:0] nm_cmd_a = 4'h0;
  logic [3:0] nm_cmd_b = 4'h0;
  logic       nm_rsp_valid;
  logic       nm_rsp_ready = 1'b0;
  logic [7:0] nm_rsp_data;
  logic       nm_rsp_err;
  logic       nm_busy;
  logic [1:0] nm_dbg_state;

  alu_sequencer #(.ENABLE_MUL(0)) dut_nm (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(nm_cmd_valid), .cmd_ready(nm_cmd_ready), .cmd_op(nm_cmd_op),
    .cmd_a(nm_cmd_a), .cmd_b(nm_cmd_b),
    .rsp_valid(nm_rsp_valid), .rsp_ready(nm_rsp_ready),
    .rsp_data(nm_rsp_data), .rsp_err(nm_rsp_err),
    .busy(nm_busy), .dbg_state(nm_dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- driver tasks ----------------
  // All stimulus changes and samples happen 1ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command to an idle DUT; returns just after the accept edge.
  task automatic drive_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    drive_cmd(OP_ADD, 4'd9, 4'd8);
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL add_cmd_ready_busy: got %b want 0", cmd_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL add_busy: got %b want 1", busy); end
    vectors++; if (dbg_state !== 2'd1) begin miscompares++; $display("FAIL add_state_exec: got %0d want 1", dbg_state); end
    wait_rsp(lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL add_latency: got %0d want 2", lat); end
    vectors++; if (rsp_data !== 8'h11) begin miscompares++; $display("FAIL add_9_8: got %h want 11", rsp_data); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL add_err: got %b want 0", rsp_err); end
    consume();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_rsp_drop: got %b want 0", rsp_valid); end
    drive_cmd(OP_ADD, 4'd15, 4'd1);
    wait_rsp(lat);
    vectors++; if (rsp_data !== 8'h10) begin miscompares++; $display("FAIL add_15_1: got %h want 10", rsp_data); end
    consume();
  endtask

  task automatic test_sub_xor();
    int lat;
    drive_cmd(OP_SUB, 4'd3, 4'd5);
    wait_rsp(lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL sub_latency: got %0d want 2", lat); end
    vectors++; if (rsp_data !== 8'h1E) begin miscompares++; $display("FAIL sub_3_5: got %h want 1e", rsp_data); end
    consume();
    drive_cmd(OP_SUB, 4'd5, 4'd3);
    wait_rsp(lat);
    vectors++; if (rsp_data !== 8'h02) begin miscompares++; $display("FAIL sub_5_3: got %h want 02", rsp_data); end
    consume();
    drive_cmd(OP_SUB, 4'd7, 4'd7);
    wait_rsp(lat);
    vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL sub_7_7: got %h want 00", rsp_data); end
    consume();
    drive_cmd(OP_XOR, 4'hA, 4'h5);
    wait_rsp(lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL xor_latency: got %0d want 2", lat); end
    vectors++; if (rsp_data !== 8'h0F) begin miscompares++; $display("FAIL xor_a_5: got %h want 0f", rsp_data); end
    consume();
    drive_cmd(OP_XOR, 4'hC, 4'h6);
    wait_rsp(lat);
    vectors++; if (rsp_data !== 8'h0A) begin miscompares++; $display("FAIL xor_c_6: got %h want 0a", rsp_data); end
    consume();
  endtask

  task automatic test_mul();
    int lat;
    drive_cmd(OP_MUL, 4'd15, 4'd15);
    vectors++; if (dbg_state !== 2'd2) begin miscompares++; $display("FAIL mul_state: got %0d want 2", dbg_state); end
    wait_rsp(lat);
    vectors++; if (lat != 5) begin miscompares++; $display("FAIL mul_latency: got %0d want 5", lat); end
    vectors++; if (rsp_data !== 8'hE1) begin miscompares++; $display("FAIL mul_15_15: got %h want e1", rsp_data); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL mul_err: got %b want 0", rsp_err); end
    consume();
    drive_cmd(OP_MUL, 4'd0, 4'd7);
    wait_rsp(lat);
    vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL mul_0_7: got %h want 00", rsp_data); end
    consume();
    drive_cmd(OP_MUL, 4'd13, 4'd11);
    wait_rsp(lat);
    vectors++; if (rsp_data !== 8'h8F) begin miscompares++; $display("FAIL mul_13_11: got %h want 8f", rsp_data); end
    consume();
  endtask

  task automatic test_resp_hold();
    int lat;
    drive_cmd(OP_MUL, 4'd6, 4'd7);
    wait_rsp(lat);
    vectors++; if (lat != 5) begin miscompares++; $display("FAIL hold_latency: got %0d want 5", lat); end
    // A second command is offered while the response is still pending.
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_a     = 4'd1;
    cmd_b     = 4'd1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (rsp_data !== 8'h2A) begin miscompares++; $display("FAIL hold_data[%0d]: got %h want 2a", i, rsp_data); end
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid[%0d]: got %b want 1", i, rsp_valid); end
      vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL hold_cmd_ready[%0d]: got %b want 0", i, cmd_ready); end
      tick();
    end
    consume();
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL hold_idle_after: got %b want 1", cmd_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL hold_valid_after: got %b want 0", rsp_valid); end
    tick();
    cmd_valid = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL hold_next_accept: got %b want 1", busy); end
    wait_rsp(lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL hold_next_latency: got %0d want 2", lat); end
    vectors++; if (rsp_data !== 8'h02) begin miscompares++; $display("FAIL hold_next_data: got %h want 02", rsp_data); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    rsp_ready = 1'b1;
    drive_cmd(OP_XOR, 4'h3, 4'h5);
    vectors++; if (dbg_state !== 2'd1) begin miscompares++; $display("FAIL b2b_ready_ignored: got %0d want 1", dbg_state); end
    wait_rsp(lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL b2b_lat1: got %0d want 2", lat); end
    vectors++; if (rsp_data !== 8'h06) begin miscompares++; $display("FAIL b2b_data1: got %h want 06", rsp_data); end
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_pulse: got %b want 0", rsp_valid); end
    drive_cmd(OP_ADD, 4'd7, 4'd9);
    wait_rsp(lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL b2b_lat2: got %0d want 2", lat); end
    vectors++; if (rsp_data !== 8'h10) begin miscompares++; $display("FAIL b2b_data2: got %h want 10", rsp_data); end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    drive_cmd(OP_MUL, 4'd15, 4'd15);
    tick();
    tick();
    vectors++; if (dbg_state !== 2'd2) begin miscompares++; $display("FAIL rst_pre_state: got %0d want 2", dbg_state); end
    rst_n = 1'b0;
    #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data); end
    vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    tick();
    tick();
    rst_n = 1'b1;
    drive_cmd(OP_ADD, 4'd1, 4'd1);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_first_accept: got %b want 1", busy); end
    wait_rsp(lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL rst_add_latency: got %0d want 2", lat); end
    vectors++; if (rsp_data !== 8'h02) begin miscompares++; $display("FAIL rst_add_data: got %h want 02", rsp_data); end
    consume();
  endtask

  task automatic test_mul_disabled();
    int lat;
    nm_cmd_valid = 1'b1;
    nm_cmd_op    = OP_MUL;
    nm_cmd_a     = 4'd3;
    nm_cmd_b     = 4'd3;
    tick();
    nm_cmd_valid = 1'b0;
    vectors++; if (nm_dbg_state !== 2'd1) begin miscompares++; $display("FAIL nm_state_exec: got %0d want 1", nm_dbg_state); end
    lat = 0;
    while (nm_rsp_valid !== 1'b1 && lat < 30) begin tick(); lat++; end
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL nm_latency: got %0d want 2", lat); end
    vectors++; if (nm_rsp_err !== 1'b1) begin miscompares++; $display("FAIL nm_err: got %b want 1", nm_rsp_err); end
    vectors++; if (nm_rsp_data !== 8'h00) begin miscompares++; $display("FAIL nm_data: got %h want 00", nm_rsp_data); end
    nm_rsp_ready = 1'b1;
    tick();
    nm_rsp_ready = 1'b0;
    nm_cmd_valid = 1'b1;
    nm_cmd_op    = OP_ADD;
    nm_cmd_a     = 4'd2;
    nm_cmd_b     = 4'd3;
    tick();
    nm_cmd_valid = 1'b0;
    lat = 0;
    while (nm_rsp_valid !== 1'b1 && lat < 30) begin tick(); lat++; end
    vectors++; if (nm_rsp_data !== 8'h05) begin miscompares++; $display("FAIL nm_add_data: got %h want 05", nm_rsp_data); end
    vectors++; if (nm_rsp_err !== 1'b0) begin miscompares++; $display("FAIL nm_add_err: got %b want 0", nm_rsp_err); end
    nm_rsp_ready = 1'b1;
    tick();
    nm_rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_xor();
    test_mul();
    test_resp_hold();
    test_back_to_back();
    test_reset_mid_mul();
    test_mul_disabled();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
